// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DDONE  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

  localparam int PCTRL_NSTAGES = 5;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - datapath <-> stall/flush controller signal bundle
interface pipeline_ctrl_if #(
  parameter int NSTAGES = pipeline_ctrl_pkg::PCTRL_NSTAGES,
  parameter int CNTW    = 32
);
  logic               ihit;
  logic               dhit;
  logic               ldst;
  logic               ld_use;
  logic               brtaken;
  logic               halt;
  logic [NSTAGES-1:0] en;
  logic [NSTAGES-1:0] flush;
  logic               dreq_en;
  logic               halted;
  logic [CNTW-1:0]    stall_cnt;
  logic [CNTW-1:0]    flush_cnt;

  // datapath side
  modport master (
    output ihit, dhit, ldst, ld_use, brtaken, halt,
    input  en, flush, dreq_en, halted, stall_cnt, flush_cnt
  );

  // controller side
  modport slave (
    input  ihit, dhit, ldst, ld_use, brtaken, halt,
    output en, flush, dreq_en, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - N-stage stall/flush controller with data-done tracking,
// sticky halt and saturating stall/flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NSTAGES  = PCTRL_NSTAGES,
  parameter int BR_STAGE = 2,
  parameter int CNTW     = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  pipeline_ctrl_if.slave       bus
);

  localparam logic [NSTAGES-1:0] ONE        = NSTAGES'(1);
  // latches 1..BR_STAGE hold wrong-path instructions on a taken branch
  localparam logic [NSTAGES-1:0] BR_FLUSH   = ((ONE << (BR_STAGE + 1)) - ONE) & ~ONE;
  localparam logic [NSTAGES-1:0] LU_HOLD    = (ONE << BR_STAGE) - ONE;
  localparam logic [NSTAGES-1:0] LU_BUBBLE  = ONE << BR_STAGE;

  pctrl_state_t state;
  logic         halted_q;
  logic         mem_ok;
  logic         adv;
  logic [NSTAGES-1:0] en_c;
  logic [NSTAGES-1:0] flush_c;

  assign mem_ok = ~bus.ldst | bus.dhit | (state == DDONE);
  assign adv    = bus.ihit & mem_ok & (state != HALTED);

  always_comb begin
    en_c    = {NSTAGES{adv}};
    flush_c = '0;
    if (adv && bus.brtaken) begin
      flush_c = BR_FLUSH;
    end else if (adv && bus.ld_use) begin
      en_c    = ~LU_HOLD;
      flush_c = LU_BUBBLE;
    end
    if (!nRST) begin
      en_c    = '0;
      flush_c = '0;
    end
  end

  assign bus.en      = en_c;
  assign bus.flush   = flush_c;
  assign bus.dreq_en = nRST & bus.ldst & (state == RUN);
  assign bus.halted  = halted_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state)
        HALTED: begin
          state    <= HALTED;
          halted_q <= 1'b1;
        end
        default: begin
          if (adv && bus.halt) begin
            state    <= HALTED;
            halted_q <= 1'b1;
          end else if ((state == RUN) && bus.ldst && bus.dhit && !bus.ihit) begin
            // access finished ahead of fetch: remember it so it is not re-issued
            state <= DDONE;
          end else if ((state == DDONE) && adv) begin
            state <= RUN;
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (~adv & (state != HALTED)),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (adv & bus.brtaken),
    .count (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic CLK;
  logic nRST;

  int checks;
  int failures;

  pipeline_ctrl_if #(.NSTAGES(5), .CNTW(32)) pb ();
  pipeline_ctrl_if #(.NSTAGES(5), .CNTW(4))  ps ();

  assign ps.ihit    = pb.ihit;
  assign ps.dhit    = pb.dhit;
  assign ps.ldst    = pb.ldst;
  assign ps.ld_use  = pb.ld_use;
  assign ps.brtaken = pb.brtaken;
  assign ps.halt    = pb.halt;

  pipeline_ctrl #(.NSTAGES(5), .BR_STAGE(2), .CNTW(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (pb)
  );

  pipeline_ctrl #(.NSTAGES(5), .BR_STAGE(2), .CNTW(4)) dut_small (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (ps)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ihit, input logic dhit, input logic ldst,
                       input logic ld_use, input logic brtaken, input logic halt);
    pb.ihit    = ihit;
    pb.dhit    = dhit;
    pb.ldst    = ldst;
    pb.ld_use  = ld_use;
    pb.brtaken = brtaken;
    pb.halt    = halt;
    #1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nRST     = 1'b0;
    drive(1, 0, 0, 0, 0, 0);
    step();

    // reset
    check("rst_en", 32'(pb.en), 32'h0);
    check("rst_flush", 32'(pb.flush), 32'h0);
    check("rst_stall", pb.stall_cnt, 32'd0);
    check("rst_fcnt", pb.flush_cnt, 32'd0);
    check("rst_halted", 32'(pb.halted), 32'd0);
    nRST = 1'b1;
    #1;
    check("rel_en", 32'(pb.en), 32'h1f);

    // load-use
    drive(1, 0, 0, 1, 0, 0);
    check("lu_en", 32'(pb.en), 32'h1c);
    check("lu_flush", 32'(pb.flush), 32'h04);
    step();
    check("lu_stall", pb.stall_cnt, 32'd0);

    // branch beats load-use
    drive(1, 0, 0, 1, 1, 0);
    check("br_en", 32'(pb.en), 32'h1f);
    check("br_flush", 32'(pb.flush), 32'h06);
    step();
    check("br_fcnt", pb.flush_cnt, 32'd1);

    // branch without advance: no flush, no count
    drive(0, 0, 0, 0, 1, 0);
    check("brstall_flush", 32'(pb.flush), 32'h0);
    check("brstall_en", 32'(pb.en), 32'h0);
    step();
    check("brstall_fcnt", pb.flush_cnt, 32'd1);
    check("brstall_stall", pb.stall_cnt, 32'd1);

    // dhit and ihit together stays in RUN
    drive(1, 1, 1, 0, 0, 0);
    check("both_en", 32'(pb.en), 32'h1f);
    step();
    drive(0, 0, 1, 0, 0, 0);
    check("both_dreq", 32'(pb.dreq_en), 32'd1);

    // data completes before fetch
    drive(0, 1, 1, 0, 0, 0);
    check("dd_en", 32'(pb.en), 32'h0);
    check("dd_dreq0", 32'(pb.dreq_en), 32'd1);
    step();
    drive(0, 0, 1, 0, 0, 0);
    check("dd_dreq1", 32'(pb.dreq_en), 32'd0);
    step();
    drive(0, 1, 1, 0, 0, 0);
    check("dd_dreq2", 32'(pb.dreq_en), 32'd0);
    step();
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(1, 0, 1, 0, 0, 0);
    check("dd_adv_en", 32'(pb.en), 32'h1f);
    step();
    check("dd_stall", pb.stall_cnt, 32'd5);
    check("dd_run_dreq", 32'(pb.dreq_en), 32'd1);

    // halt without advance is ignored
    drive(0, 0, 0, 0, 0, 1);
    step();
    check("halt_noadv", 32'(pb.halted), 32'd0);
    check("halt_noadv_stall", pb.stall_cnt, 32'd6);

    // halt with advance latches
    drive(1, 0, 0, 0, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 0);
    check("halted", 32'(pb.halted), 32'd1);
    check("halted_en", 32'(pb.en), 32'h0);
    step();
    step();
    check("halted_sticky", 32'(pb.halted), 32'd1);
    check("halted_stall", pb.stall_cnt, 32'd6);

    // reset pulse clears halt
    nRST = 1'b0;
    #2;
    check("halt_rst_en", 32'(pb.en), 32'h0);
    nRST = 1'b1;
    #1;
    check("halt_rst_halted", 32'(pb.halted), 32'd0);
    check("halt_rst_stall", pb.stall_cnt, 32'd0);
    check("halt_rst_en1", 32'(pb.en), 32'h1f);

    // saturation
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    check("sat_small", 32'(ps.stall_cnt), 32'hf);
    check("sat_big", pb.stall_cnt, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
